adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched_pkg.sv | 12 +
 rtl/adder_sched_fifo.sv | 48 ++++
 rtl/adder_sched.sv | 92 +++++++++
 tb/tb_adder_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared defaults, id/tag type and width helper for the adder scheduler
package adder_sched_pkg;
  localparam int BITS_DEF  = 8;
  localparam int NUM_DEF   = 8;
  localparam int REQS_DEF  = 4;
  localparam int DEPTH_DEF = 4;
  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int ID_W = ptr_w(REQS_DEF);
  typedef logic [ID_W-1:0] id_t;
endpackage

// File: rtl/adder_sched_fifo.sv
// adder_sched_fifo: synchronous FIFO with full/empty flags; head reads as zero when empty
// Ports: clk/rst_n, push_i+din_i write, pop_i advances head, dout_o head, full_o/empty_o flags
module adder_sched_fifo
  import adder_sched_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = ptr_w(D);
  localparam int CW = $clog2(D + 1);
  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == CW'(D);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];
  always_comb begin
    wr_d  = do_push ? ((wr_q == AW'(D - 1)) ? '0 : wr_q + AW'(1)) : wr_q;
    rd_d  = do_pop ? ((rd_q == AW'(D - 1)) ? '0 : rd_q + AW'(1)) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/adder_sched.sv
// adder_sched: round-robin arbiter sharing one pipelined adder among requesters, in-order responses
// Ports: req_valid/req_ready/req_data requester side; add_valid/add_i/add_o/add_valid_out adder side;
//        rsp_valid/rsp_ready/rsp_id/rsp_sum response side; err sticky result-without-issue flag
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int NUM   = NUM_DEF,
  parameter int REQS  = REQS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int IW   = ptr_w(REQS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REQS-1:0]          req_valid,
  output logic [REQS-1:0]          req_ready,
  input  logic [REQS*NUM*BITS-1:0] req_data,
  output logic                     add_valid,
  output logic [NUM*BITS-1:0]      add_i,
  input  logic [BITS-1:0]          add_o,
  input  logic                     add_valid_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IW-1:0]            rsp_id,
  output logic [BITS-1:0]          rsp_sum,
  output logic                     err
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [IW-1:0]      rr_q, rr_d, win, idx, tag_head;
  logic [CW-1:0]      credit_q, credit_d;
  logic               found, grant, err_q, err_d;
  logic               tag_full, tag_empty, rsp_full, rsp_empty, ret_ok, rsp_pop;
  logic [IW+BITS-1:0] rsp_head;
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < REQS; i++) begin
      idx = IW'((int'(rr_q) + i) % REQS);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  // rst_n gates the grant so req_ready drops the instant reset asserts, even with requests pending
  assign grant     = rst_n && found && (credit_q < CW'(DEPTH)) && !tag_full;
  assign req_ready = grant ? (REQS'(1) << win) : '0;
  assign add_valid = grant;
  assign add_i     = grant ? req_data[int'(win)*NUM*BITS +: NUM*BITS] : '0;
  assign ret_ok    = add_valid_out && !tag_empty && !rsp_full;
  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign {rsp_id, rsp_sum} = rsp_head;
  assign err       = err_q;
  always_comb begin
    rr_d     = grant ? IW'((int'(win) + 1) % REQS) : rr_q;
    credit_d = credit_q + CW'(grant) - CW'(rsp_pop);
    err_d    = err_q || (add_valid_out && tag_empty);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end
  adder_sched_fifo #(.W(IW), .D(DEPTH)) u_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant),
    .din_i   (win),
    .pop_i   (ret_ok),
    .dout_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );
  adder_sched_fifo #(.W(IW + BITS), .D(DEPTH)) u_rsp (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ret_ok),
    .din_i   ({tag_head, add_o}),
    .pop_i   (rsp_pop),
    .dout_o  (rsp_head),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );
endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: scoreboard bench for adder_sched with a two-register pipelined adder model
module tb_adder_sched;
  import adder_sched_pkg::*;
  localparam int BITS = 8, NUM = 8, REQS = 4, DEPTH = 4;
  logic                     clk = 1'b0, rst_n = 1'b0;
  logic [REQS-1:0]          req_valid = '0, req_ready;
  logic [REQS*NUM*BITS-1:0] req_data = '0;
  logic                     add_valid, add_valid_out, inject = 1'b0;
  logic [NUM*BITS-1:0]      add_i;
  logic [BITS-1:0]          add_o, rsp_sum;
  logic                     rsp_valid, rsp_ready = 1'b0, err;
  id_t                      rsp_id;
  int errors = 0, checks = 0;
  typedef struct packed { id_t id; logic [BITS-1:0] sum; } exp_t;
  exp_t exp_q[$];

  adder_sched #(.BITS(BITS), .NUM(NUM), .REQS(REQS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .add_valid(add_valid), .add_i(add_i), .add_o(add_o), .add_valid_out(add_valid_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .err(err)
  );

  always #5 clk = ~clk;

  // shared adder: result leaves two edges after issue, so the response is visible three cycles on
  function automatic logic [BITS-1:0] add_all(logic [NUM*BITS-1:0] v);
    logic [BITS-1:0] s;
    s = '0;
    for (int k = 0; k < NUM; k++) s += v[k*BITS +: BITS];
    return s;
  endfunction
  logic pv0, pv1;
  logic [BITS-1:0] ps0, ps1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv0 <= 1'b0; pv1 <= 1'b0; ps0 <= '0; ps1 <= '0;
    end else begin
      pv0 <= add_valid; pv1 <= pv0; ps0 <= add_all(add_i); ps1 <= ps0;
    end
  end
  assign add_valid_out = pv1 | inject;
  assign add_o = ps1;

  task automatic chk(string n, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, expv);
    end
  endtask

  task automatic push_exp(int id, int s);
    exp_t e;
    e.id = id_t'(id);
    e.sum = BITS'(s);
    exp_q.push_back(e);
  endtask

  task automatic set_ops(int r, logic [BITS-1:0] v);
    for (int k = 0; k < NUM; k++) req_data[(r*NUM+k)*BITS +: BITS] = v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d sum %0h, expected no response", rsp_id, rsp_sum);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_sum", rsp_sum, e.sum);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_add_valid", add_valid, 0);
    chk("rst_add_i", add_i, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_err", err, 0);
    req_valid = '0;
    rst_n = 1'b1;
    next_cycle();
    // single request from r2, all operands 1
    rsp_ready = 1'b1;
    set_ops(2, 8'h01);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    chk("single_add_valid", add_valid, 1);
    chk("single_add_i", add_i, 64'h0101010101010101);
    push_exp(2, 8);
    next_cycle();
    req_valid = '0;
    lat = 1;
    @(negedge clk);
    chk("idle_add_i", add_i, 0);
    while (!rsp_valid && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    chk("single_latency", lat, 3);
    drain();
    // continuous round robin, r -> sum 8*(r+1)
    do_reset();
    for (int r = 0; r < REQS; r++) set_ops(r, BITS'(r + 1));
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_grant", req_ready, 1 << (i % 4));
      push_exp(i % 4, 8 * (i % 4 + 1));
      next_cycle();
    end
    drain();
    // credit back-pressure: four grants, stall, one pop, one more grant
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_grant", req_ready, 1 << i);
      push_exp(i, 8 * (i + 1));
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_blocked", req_ready, 0);
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_cycle", req_ready, 0);
    next_cycle();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_one_more", req_ready, 4'b0001);
    push_exp(0, 8);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_blocked_again", req_ready, 0);
      next_cycle();
    end
    drain();
    // wrap: eight 0xFF -> 0xF8; r0 operands 1..8 -> 0x24
    rsp_ready = 1'b1;
    set_ops(1, 8'hFF);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("wrap_ready", req_ready, 4'b0010);
    push_exp(1, 8'hF8);
    next_cycle();
    for (int k = 0; k < NUM; k++) req_data[k*BITS +: BITS] = BITS'(k + 1);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("mixed_ready", req_ready, 4'b0001);
    push_exp(0, 8'h24);
    next_cycle();
    drain();
    // spurious result with nothing outstanding
    chk("err_before", err, 0);
    inject = 1'b1;
    next_cycle();
    inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("err_sticky", err, 1);
      chk("err_no_rsp", rsp_valid, 0);
      next_cycle();
    end
    // asynchronous reset with three sums buffered and requests pending
    rsp_ready = 1'b0;
    req_valid = 4'b0111;
    repeat (3) next_cycle();
    req_valid = '0;
    repeat (3) next_cycle();
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    req_valid = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 0);
    chk("arst_add_valid", add_valid, 0);
    chk("arst_add_i", add_i, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_id", rsp_id, 0);
    chk("arst_rsp_sum", rsp_sum, 0);
    chk("arst_err", err, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0001);
    push_exp(0, 8'h24);
    next_cycle();
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
